// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
//   Power-up feeder for the multi-byte I2C register-write stage. Walks a
//   byte-stream configuration table in an external synchronous ROM. Each
//   entry is: header N, device byte (bits 6:0), register byte, N data bytes.
//   N = 0 ends the table, N > 15 is malformed. For every entry the payload is
//   pushed into the write stage's FIFO, then one start is issued and the
//   sequencer waits for done / failure / timeout.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   go                  pulse: run the table from ROM address 0 (ignored while busy)
//   busy                high from accepted go until the sequence ends
//   seq_done            one-cycle pulse at successful end of table
//   seq_error           level, set on failure, cleared by the next accepted go
//   error_entry         0-based index of the failing entry (valid with seq_error)
//   rom_addr / rom_data ROM read port; data valid one cycle after the address
//   wr_dev_address, wr_reg_address, wr_byte_width, wr_start
//                       command to the write stage, held stable through WAIT
//   wr_done, wr_failure write-stage completion / failure (sampled in WAIT only)
//   fifo_data, fifo_wr_en, fifo_full
//                       payload bytes into the write-stage FIFO
module i2c_config_sequencer #(
  parameter int ROM_AW         = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [7:0]        error_entry,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [6:0]        wr_dev_address,
  output logic [7:0]        wr_reg_address,
  output logic [3:0]        wr_byte_width,
  output logic              wr_start,
  input  logic              wr_done,
  input  logic              wr_failure,
  output logic [7:0]        fifo_data,
  output logic              fifo_wr_en,
  input  logic              fifo_full
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_HDR,
    S_FETCH_DEV,
    S_FETCH_REG,
    S_PUSH,
    S_FIRE,
    S_WAIT,
    S_FINISH_OK,
    S_FAIL
  } state_t;

  // Every ROM fetch takes two cycles: ADDR (address on the bus) and CAPT
  // (data valid, captured). HOLD parks a captured payload byte while the
  // FIFO is full.
  typedef enum logic [1:0] {
    PH_ADDR,
    PH_CAPT,
    PH_HOLD
  } phase_t;

  localparam logic [ROM_AW-1:0] ROM_LAST = '1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  phase_t           phase;
  logic [3:0]       byte_cnt;   // header N, then payload bytes still to push
  logic [7:0]       byte_hold;  // payload byte waiting for FIFO space
  logic [7:0]       entry_idx;
  logic [TO_W-1:0]  to_cnt;
  logic             at_rom_end;

  // A capture at the last ROM address may only be an end marker; any other
  // byte there would need a fetch beyond the end of the table.
  assign at_rom_end = (rom_addr == ROM_LAST);

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every branch below reads the values from the start of the cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      phase          <= PH_ADDR;
      busy           <= 1'b0;
      seq_done       <= 1'b0;
      seq_error      <= 1'b0;
      error_entry    <= '0;
      rom_addr       <= '0;
      wr_dev_address <= '0;
      wr_reg_address <= '0;
      wr_byte_width  <= '0;
      wr_start       <= 1'b0;
      fifo_data      <= '0;
      fifo_wr_en     <= 1'b0;
      byte_cnt       <= '0;
      byte_hold      <= '0;
      entry_idx      <= '0;
      to_cnt         <= '0;
    end else begin
      // NOTE: strobes default low here so each is high for exactly the one
      // cycle following the branch that raises it.
      wr_start   <= 1'b0;
      fifo_wr_en <= 1'b0;
      seq_done   <= 1'b0;

      case (state)
        S_FETCH_HDR: begin
          if (phase == PH_ADDR) begin
            phase <= PH_CAPT;
          end else begin
            phase <= PH_ADDR;
            if (rom_data == 8'd0) begin
              seq_done <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FINISH_OK;
            end else if (rom_data > 8'd15 || at_rom_end) begin
              seq_error   <= 1'b1;
              error_entry <= entry_idx;
              busy        <= 1'b0;
              state       <= S_FAIL;
            end else begin
              byte_cnt <= rom_data[3:0];
              rom_addr <= rom_addr + ROM_AW'(1);
              state    <= S_FETCH_DEV;
            end
          end
        end

        S_FETCH_DEV: begin
          if (phase == PH_ADDR) begin
            phase <= PH_CAPT;
          end else begin
            phase <= PH_ADDR;
            if (at_rom_end) begin
              seq_error   <= 1'b1;
              error_entry <= entry_idx;
              busy        <= 1'b0;
              state       <= S_FAIL;
            end else begin
              wr_dev_address <= rom_data[6:0];
              rom_addr       <= rom_addr + ROM_AW'(1);
              state          <= S_FETCH_REG;
            end
          end
        end

        S_FETCH_REG: begin
          if (phase == PH_ADDR) begin
            phase <= PH_CAPT;
          end else begin
            phase <= PH_ADDR;
            if (at_rom_end) begin
              seq_error   <= 1'b1;
              error_entry <= entry_idx;
              busy        <= 1'b0;
              state       <= S_FAIL;
            end else begin
              wr_reg_address <= rom_data;
              wr_byte_width  <= byte_cnt;
              rom_addr       <= rom_addr + ROM_AW'(1);
              state          <= S_PUSH;
            end
          end
        end

        S_PUSH: begin
          case (phase)
            PH_ADDR: phase <= PH_CAPT;
            PH_CAPT: begin
              if (at_rom_end) begin
                phase       <= PH_ADDR;
                seq_error   <= 1'b1;
                error_entry <= entry_idx;
                busy        <= 1'b0;
                state       <= S_FAIL;
              end else begin
                // The next ROM fetch can start even if this byte must wait.
                rom_addr  <= rom_addr + ROM_AW'(1);
                byte_hold <= rom_data;
                if (!fifo_full) begin
                  fifo_data  <= rom_data;
                  fifo_wr_en <= 1'b1;
                  byte_cnt   <= byte_cnt - 4'd1;
                  phase      <= PH_ADDR;
                  if (byte_cnt == 4'd1) state <= S_FIRE;
                end else begin
                  phase <= PH_HOLD;
                end
              end
            end
            default: begin
              if (!fifo_full) begin
                fifo_data  <= byte_hold;
                fifo_wr_en <= 1'b1;
                byte_cnt   <= byte_cnt - 4'd1;
                phase      <= PH_ADDR;
                if (byte_cnt == 4'd1) state <= S_FIRE;
              end
            end
          endcase
        end

        S_FIRE: begin
          wr_start <= 1'b1;
          to_cnt   <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // Failure has priority over a simultaneous done.
          if (wr_failure || (!wr_done && to_cnt == TO_LAST)) begin
            seq_error   <= 1'b1;
            error_entry <= entry_idx;
            busy        <= 1'b0;
            state       <= S_FAIL;
          end else if (wr_done) begin
            if (entry_idx != 8'hFF) entry_idx <= entry_idx + 8'd1;
            phase <= PH_ADDR;
            state <= S_FETCH_HDR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        // IDLE, FINISH_OK and FAIL: busy is already low, so a go is accepted.
        // The completion/failure outputs were raised on entry to FINISH_OK or
        // FAIL so they line up with the cycle the decision was made.
        default: begin
          state <= S_IDLE;
          if (go) begin
            seq_error <= 1'b0;
            rom_addr  <= '0;
            entry_idx <= '0;
            busy      <= 1'b1;
            phase     <= PH_ADDR;
            state     <= S_FETCH_HDR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer
//   Directed bench: a ROM model, a write-stage responder and a FIFO-full
//   generator around i2c_config_sequencer. Expected values are hand-computed
//   per table.
module tb_i2c_config_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        busy, seq_done, seq_error;
  logic [7:0]  error_entry;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [6:0]  wr_dev_address;
  logic [7:0]  wr_reg_address;
  logic [3:0]  wr_byte_width;
  logic        wr_start;
  logic        wr_done = 1'b0;
  logic        wr_failure = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_wr_en;
  logic        fifo_full = 1'b0;

  i2c_config_sequencer #(
    .ROM_AW(8),
    .TIMEOUT_CYCLES(50),
    .TO_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .busy(busy),
    .seq_done(seq_done),
    .seq_error(seq_error),
    .error_entry(error_entry),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .wr_dev_address(wr_dev_address),
    .wr_reg_address(wr_reg_address),
    .wr_byte_width(wr_byte_width),
    .wr_start(wr_start),
    .wr_done(wr_done),
    .wr_failure(wr_failure),
    .fifo_data(fifo_data),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  logic [7:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Stimulus configuration (written only by the main initial block).
  int  done_delay = 5;
  int  fail_idx   = -1;
  bit  never_done = 1'b0;
  bit  want_full  = 1'b0;
  bit  clr_mon    = 1'b0;

  // Monitor / responder state (written only by the negedge block).
  logic [7:0]  fifo_q [$];
  logic [18:0] start_q [$];
  int  start_cyc, err_cyc, done_cnt, viol, resp_wait, full_left;
  bit  err_seen, err_prev, resp_pend, resp_fail, full_fired;

  always @(negedge clk) begin
    if (clr_mon || !reset) begin
      fifo_q.delete();
      start_q.delete();
      start_cyc  = 0;
      err_cyc    = 0;
      done_cnt   = 0;
      viol       = 0;
      err_seen   = 1'b0;
      err_prev   = seq_error;
      resp_pend  = 1'b0;
      resp_fail  = 1'b0;
      resp_wait  = 0;
      full_left  = 0;
      full_fired = 1'b0;
      wr_done    = 1'b0;
      wr_failure = 1'b0;
      fifo_full  = 1'b0;
    end else begin
      wr_done    = 1'b0;
      wr_failure = 1'b0;
      if (fifo_wr_en) begin
        if (fifo_full) viol++;
        fifo_q.push_back(fifo_data);
      end
      // FIFO-full window: 10 cycles, opened right after the first byte write.
      if (full_left > 0) begin
        full_left--;
        if (full_left == 0) fifo_full = 1'b0;
      end else if (want_full && !full_fired && fifo_wr_en) begin
        full_fired = 1'b1;
        fifo_full  = 1'b1;
        full_left  = 10;
      end
      if (resp_pend) begin
        if (resp_wait == 0) begin
          resp_pend = 1'b0;
          if (resp_fail) wr_failure = 1'b1;
          else           wr_done    = 1'b1;
        end else begin
          resp_wait--;
        end
      end
      if (wr_start) begin
        resp_fail = (start_q.size() == fail_idx);
        start_q.push_back({wr_dev_address, wr_reg_address, wr_byte_width});
        start_cyc = cyc;
        if (!never_done) begin
          resp_pend = 1'b1;
          resp_wait = done_delay - 1;
        end
      end
      if (seq_done) done_cnt++;
      if (seq_error && !err_prev) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      err_prev = seq_error;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] tbl [$];
  logic [7:0] exp_q [$];
  int go_cyc;

  task automatic load_tbl();
    foreach (rom[i]) rom[i] = 8'd0;
    foreach (tbl[i]) rom[i] = tbl[i];
  endtask

  // Called at posedge+2. Clears the monitors, then pulses go for one cycle.
  task automatic start_seq();
    clr_mon = 1'b1;
    @(posedge clk); #2;
    clr_mon = 1'b0;
    go = 1'b1;
    @(posedge clk); #2;
    go = 1'b0;
    go_cyc = cyc;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done_cnt == 0 && !err_seen && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check(tag, 64'(done_cnt > 0 || err_seen), 64'd1);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 64'(fifo_q.size()), 64'(exp_q.size()));
    if (fifo_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check(tag, 64'(fifo_q[i]), 64'(exp_q[i]));
  endtask

  function automatic logic [47:0] all_outs();
    return {busy, seq_done, seq_error, error_entry, rom_addr, wr_dev_address,
            wr_reg_address, wr_byte_width, wr_start, fifo_data, fifo_wr_en};
  endfunction

  initial begin
    reset = 1'b0;
    go    = 1'b0;
    foreach (rom[i]) rom[i] = 8'd0;
    repeat (3) @(posedge clk); #2;
    check("reset_outputs", 64'(all_outs()), 64'd0);
    reset = 1'b1;
    @(posedge clk); #2;

    // 1: single 2-byte entry, done 5 cycles after start.
    tbl = {8'd2, 8'h29, 8'h80, 8'hAA, 8'hBB, 8'd0};
    load_tbl();
    start_seq();
    check("t1_busy_after_go", 64'(busy), 64'd1);
    check("t1_rom_addr_after_go", 64'(rom_addr), 64'd0);
    wait_end("t1_end");
    exp_q = {8'hAA, 8'hBB};
    check_bytes("t1_byte");
    check("t1_starts", 64'(start_q.size()), 64'd1);
    if (start_q.size() == 1)
      check("t1_cmd", 64'(start_q[0]), 64'({7'h29, 8'h80, 4'd2}));
    check("t1_start_latency", 64'(start_cyc - go_cyc), 64'd11);
    check("t1_done", 64'(done_cnt), 64'd1);
    check("t1_seq_error", 64'(seq_error), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // 2: entries N=1,3,15, with a go while busy that must be ignored.
    tbl = {8'd1, 8'h10, 8'h01, 8'h11,
           8'd3, 8'h11, 8'h02, 8'h21, 8'h22, 8'h23,
           8'd15, 8'h12, 8'h03};
    exp_q = {8'h11, 8'h21, 8'h22, 8'h23};
    for (int i = 0; i < 15; i++) begin
      tbl.push_back(8'h30 + 8'(i));
      exp_q.push_back(8'h30 + 8'(i));
    end
    tbl.push_back(8'd0);
    load_tbl();
    start_seq();
    repeat (20) @(posedge clk); #2;
    go = 1'b1;
    @(posedge clk); #2;
    go = 1'b0;
    wait_end("t2_end");
    check_bytes("t2_byte");
    check("t2_starts", 64'(start_q.size()), 64'd3);
    if (start_q.size() == 3) begin
      check("t2_cmd0", 64'(start_q[0]), 64'({7'h10, 8'h01, 4'd1}));
      check("t2_cmd1", 64'(start_q[1]), 64'({7'h11, 8'h02, 4'd3}));
      check("t2_cmd2", 64'(start_q[2]), 64'({7'h12, 8'h03, 4'd15}));
    end
    check("t2_done", 64'(done_cnt), 64'd1);

    // 3: FIFO full for 10 cycles while the 2nd byte of a 3-byte entry waits.
    tbl = {8'd3, 8'h29, 8'h40, 8'hC1, 8'hC2, 8'hC3, 8'd0};
    load_tbl();
    want_full = 1'b1;
    start_seq();
    wait_end("t3_end");
    want_full = 1'b0;
    exp_q = {8'hC1, 8'hC2, 8'hC3};
    check_bytes("t3_byte");
    check("t3_full_window", 64'(full_fired), 64'd1);
    check("t3_wr_while_full", 64'(viol), 64'd0);
    check("t3_done", 64'(done_cnt), 64'd1);

    // 4: wr_failure while waiting on entry 1 of 3.
    tbl = {8'd1, 8'h20, 8'h00, 8'h01,
           8'd1, 8'h21, 8'h01, 8'h02,
           8'd1, 8'h22, 8'h02, 8'h03, 8'd0};
    load_tbl();
    fail_idx = 1;
    start_seq();
    wait_end("t4_end");
    fail_idx = -1;
    check("t4_seq_error", 64'(seq_error), 64'd1);
    check("t4_error_entry", 64'(error_entry), 64'd1);
    check("t4_starts", 64'(start_q.size()), 64'd2);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_done", 64'(done_cnt), 64'd0);

    // 5: write stage never completes; timeout 50 cycles after wr_start.
    tbl = {8'd1, 8'h29, 8'h10, 8'h55, 8'd0};
    load_tbl();
    never_done = 1'b1;
    start_seq();
    wait_end("t5_end");
    never_done = 1'b0;
    check("t5_seq_error", 64'(seq_error), 64'd1);
    check("t5_timeout_cycles", 64'(err_cyc - start_cyc), 64'd50);
    check("t5_error_entry", 64'(error_entry), 64'd0);

    // 6: malformed header at entry 0.
    tbl = {8'h20, 8'h29, 8'h10, 8'h55, 8'd0};
    load_tbl();
    start_seq();
    wait_end("t6_end");
    check("t6_seq_error", 64'(seq_error), 64'd1);
    check("t6_error_entry", 64'(error_entry), 64'd0);
    check("t6_fifo_writes", 64'(fifo_q.size()), 64'd0);
    check("t6_starts", 64'(start_q.size()), 64'd0);

    // 7: reset mid-PUSH, then a fresh run from address 0.
    tbl = {8'd15, 8'h29, 8'h10};
    for (int i = 0; i < 15; i++) tbl.push_back(8'hE0 + 8'(i));
    tbl.push_back(8'd0);
    load_tbl();
    start_seq();
    begin
      int n = 0;
      while (fifo_q.size() < 3 && n < 200) begin
        @(posedge clk);
        n++;
      end
    end
    #2;
    check("t7_reached_push", 64'(fifo_q.size() >= 3), 64'd1);
    reset = 1'b0;
    #1;
    check("t7_outputs_in_reset", 64'(all_outs()), 64'd0);
    @(posedge clk); #2;
    check("t7_outputs_held", 64'(all_outs()), 64'd0);
    reset = 1'b1;
    tbl = {8'd2, 8'h29, 8'h80, 8'hAA, 8'hBB, 8'd0};
    load_tbl();
    @(posedge clk); #2;
    start_seq();
    wait_end("t7_end");
    exp_q = {8'hAA, 8'hBB};
    check_bytes("t7_byte");
    check("t7_done", 64'(done_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
